// File: rtl/axi_wr_arbiter.sv
// Two-requester round-robin AXI write-address/response sequencer with one transaction outstanding.
// Optional macro BRESP_CHK_EN adds a sticky bresp error flag with the ID of the first failing write.
module axi_wr_arbiter #(
    parameter logic [3:0] ID_REQ0 = 4'h1,
    parameter logic [3:0] ID_REQ1 = 4'h2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_rq,
    input  logic [31:0]  req0_addr,
    input  logic [127:0] req0_wdata,
    output logic         req0_ack,
    output logic         req0_done,
    input  logic         req1_rq,
    input  logic [31:0]  req1_addr,
    input  logic [127:0] req1_wdata,
    output logic         req1_ack,
    output logic         req1_done,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  awaddr,
    output logic [3:0]   awid,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         next_rq,
    output logic [3:0]   next_id,
    output logic [127:0] next_wdata,
    input  logic         finish_wd,
    input  logic [3:0]   finish_id,
    input  logic         bvalid,
    output logic         bready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    output logic         wr_err,
    output logic [3:0]   err_id
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        WST  = 3'd2,
        WD   = 3'd3,
        BR   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           rr_ptr;
    logic           hold_owner;
    logic [31:0]    hold_addr;
    logic [127:0]   hold_wdata;
    logic [3:0]     hold_id;
    logic           grant_any;
    logic           grant_sel;
    logic           resp_match;
    logic           unused_finish_id;

    // Only one write is ever in flight, so the completion ID carries no extra information.
    assign unused_finish_id = ^finish_id;

    assign grant_any  = req0_rq | req1_rq;
    assign grant_sel  = (req0_rq & req1_rq) ? rr_ptr : req1_rq;
    assign resp_match = bvalid & (bid == hold_id);

    assign awaddr     = hold_addr;
    assign awid       = hold_id;
    assign awlen      = 8'd3;
    assign awsize     = 3'd2;
    assign awburst    = 2'b01;
    assign next_id    = hold_id;
    assign next_wdata = hold_wdata;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        awvalid    = 1'b0;
        next_rq    = 1'b0;
        bready     = 1'b0;
        case (state)
            IDLE: if (grant_any) state_next = AW;
            AW: begin
                awvalid = 1'b1;
                if (awready) state_next = WST;
            end
            WST: begin
                next_rq    = 1'b1;
                state_next = WD;
            end
            WD: if (finish_wd) state_next = BR;
            BR: begin
                bready = 1'b1;
                if (resp_match) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // rr_ptr names the requester that wins the next tie; it moves away from whoever was just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            hold_owner <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_id    <= '0;
            req0_ack   <= 1'b0;
            req1_ack   <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
        end else begin
            req0_ack  <= 1'b0;
            req1_ack  <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            if (state == IDLE && grant_any) begin
                rr_ptr     <= ~grant_sel;
                hold_owner <= grant_sel;
                hold_addr  <= grant_sel ? req1_addr  : req0_addr;
                hold_wdata <= grant_sel ? req1_wdata : req0_wdata;
                hold_id    <= grant_sel ? ID_REQ1    : ID_REQ0;
                req0_ack   <= ~grant_sel;
                req1_ack   <= grant_sel;
            end
            if (state == BR && resp_match) begin
                req0_done <= ~hold_owner;
                req1_done <= hold_owner;
            end
        end
    end

`ifdef BRESP_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err <= 1'b0;
            err_id <= '0;
        end else if (state == BR && resp_match && bresp != 2'b00 && !wr_err) begin
            wr_err <= 1'b1;
            err_id <= bid;
        end
    end
`else
    logic unused_bresp;
    assign unused_bresp = ^bresp;
    assign wr_err = 1'b0;
    assign err_id = 4'h0;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: transaction-phase model compared every cycle plus directed literal checks.
// Error-flag expectations follow BRESP_CHK_EN when it is defined.
module tb_axi_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_rq, req1_rq;
    logic [31:0]  req0_addr, req1_addr;
    logic [127:0] req0_wdata, req1_wdata;
    logic         req0_ack, req0_done, req1_ack, req1_done;
    logic         awvalid, awready;
    logic [31:0]  awaddr;
    logic [3:0]   awid;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         next_rq;
    logic [3:0]   next_id;
    logic [127:0] next_wdata;
    logic         finish_wd;
    logic [3:0]   finish_id;
    logic         bvalid, bready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         wr_err;
    logic [3:0]   err_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_wr_arbiter #(.ID_REQ0(4'h1), .ID_REQ1(4'h2)) dut (
        .clk(clk), .rst(rst),
        .req0_rq(req0_rq), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ack(req0_ack), .req0_done(req0_done),
        .req1_rq(req1_rq), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ack(req1_ack), .req1_done(req1_done),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .next_rq(next_rq), .next_id(next_id), .next_wdata(next_wdata),
        .finish_wd(finish_wd), .finish_id(finish_id),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .wr_err(wr_err), .err_id(err_id)
    );

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 address offered, 2 data command, 3 data running, 4 awaiting response.
    logic         m_started = 1'b0;
    int           m_phase = 0;
    int           m_owner = 0;
    int           m_rr = 0;
    logic [31:0]  m_addr = '0;
    logic [127:0] m_data = '0;
    logic [3:0]   m_id = '0;
    logic [1:0]   m_ack = '0;
    logic [1:0]   m_done = '0;
    logic         m_err = 1'b0;
    logic [3:0]   m_errid = '0;

    always @(posedge clk) begin : model
        int g;
        m_started <= 1'b1;
        m_ack     <= '0;
        m_done    <= '0;
        if (rst) begin
            m_phase <= 0; m_owner <= 0; m_rr <= 0;
            m_addr <= '0; m_data <= '0; m_id <= '0;
            m_err <= 1'b0; m_errid <= '0;
        end else begin
            case (m_phase)
                0: if (req0_rq || req1_rq) begin
                    g = (req0_rq && req1_rq) ? m_rr : (req0_rq ? 0 : 1);
                    m_owner  <= g;
                    m_rr     <= 1 - g;
                    m_addr   <= (g == 1) ? req1_addr : req0_addr;
                    m_data   <= (g == 1) ? req1_wdata : req0_wdata;
                    m_id     <= (g == 1) ? 4'h2 : 4'h1;
                    m_ack[g] <= 1'b1;
                    m_phase  <= 1;
                end
                1: if (awready) m_phase <= 2;
                2: m_phase <= 3;
                3: if (finish_wd) m_phase <= 4;
                4: if (bvalid && bid == m_id) begin
                    m_done[m_owner] <= 1'b1;
                    m_phase <= 0;
`ifdef BRESP_CHK_EN
                    if (bresp != 2'b00 && !m_err) begin
                        m_err   <= 1'b1;
                        m_errid <= bid;
                    end
`endif
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check_output("req0_ack", req0_ack, m_ack[0]);
            check_output("req1_ack", req1_ack, m_ack[1]);
            check_output("req0_done", req0_done, m_done[0]);
            check_output("req1_done", req1_done, m_done[1]);
            check_output("awvalid", awvalid, m_phase == 1);
            check_output("awaddr", awaddr, m_addr);
            check_output("awid", awid, m_id);
            check_output("aw_consts", {awlen, awsize, awburst}, {8'd3, 3'd2, 2'b01});
            check_output("next_rq", next_rq, m_phase == 2);
            check_output("next_id", next_id, m_id);
            check_output("next_wdata", next_wdata, m_data);
            check_output("bready", bready, m_phase == 4);
            check_output("wr_err", wr_err, m_err);
            check_output("err_id", err_id, m_errid);
        end
    end

    task automatic raise(input int who, input logic [31:0] addr, input logic [127:0] data);
        if (who == 1) begin
            req1_rq = 1'b1; req1_addr = addr; req1_wdata = data;
        end else begin
            req0_rq = 1'b1; req0_addr = addr; req0_wdata = data;
        end
    endtask

    // Waits for the next grant and plays a slave through one full write, checking literal milestones.
    task automatic serve(input int who, input logic [31:0] ex_addr, input int aw_wait,
                         input int n_wrong, input logic [1:0] resp, input bit rst_in_wd);
        bit got;
        logic [3:0] id;
        id  = (who == 1) ? 4'h2 : 4'h1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            if (req0_ack || req1_ack) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL ack_timeout actual=no_ack required=ack_within_20_cycles");
            return;
        end
        if (req0_ack) req0_rq = 1'b0;
        if (req1_ack) req1_rq = 1'b0;
        check_output("lit_ack_who", (who == 1) ? req1_ack : req0_ack, 1'b1);
        check_output("lit_awaddr", awaddr, ex_addr);
        check_output("lit_awid", awid, id);
        check_output("lit_awlen", awlen, 8'd3);
        for (int i = 0; i < aw_wait; i++) begin
            finish_wd = (i == 0);
            @(posedge clk); #1;
            finish_wd = 1'b0;
            check_output("lit_bp_awvalid", awvalid, 1'b1);
            check_output("lit_bp_awaddr", awaddr, ex_addr);
            check_output("lit_bp_next_rq", next_rq, 1'b0);
        end
        awready = 1'b1;
        @(posedge clk); #1;
        awready = 1'b0;
        check_output("lit_next_rq_on", next_rq, 1'b1);
        @(posedge clk); #1;
        check_output("lit_next_rq_off", next_rq, 1'b0);
        check_output("lit_next_id", next_id, id);
        if (rst_in_wd) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_output("lit_rst_done", {req0_done, req1_done}, 2'b00);
            check_output("lit_rst_awaddr", awaddr, 32'h0);
            check_output("lit_rst_next_id", next_id, 4'h0);
            check_output("lit_rst_wdata", next_wdata, 128'h0);
            return;
        end
        finish_wd = 1'b1;
        finish_id = id;
        @(posedge clk); #1;
        finish_wd = 1'b0;
        check_output("lit_bready", bready, 1'b1);
        for (int i = 0; i < n_wrong; i++) begin
            bvalid = 1'b1; bid = 4'h7; bresp = 2'b00;
            @(posedge clk); #1;
            check_output("lit_wrong_done", (who == 1) ? req1_done : req0_done, 1'b0);
            check_output("lit_wrong_bready", bready, 1'b1);
        end
        bvalid = 1'b1; bid = id; bresp = resp;
        @(posedge clk); #1;
        bvalid = 1'b0; bresp = 2'b00;
        check_output("lit_done", (who == 1) ? req1_done : req0_done, 1'b1);
        check_output("lit_bready_off", bready, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req0_rq = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_rq = 1'b1; req1_addr = 32'hDEAD; req1_wdata = '0;
        awready = 1'b0; finish_wd = 1'b0; finish_id = '0;
        bvalid = 1'b0; bid = '0; bresp = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        req1_rq = 1'b0;
        @(posedge clk); #1;
        check_output("lit_reset_ack", req1_ack, 1'b0);
        check_output("lit_reset_awvalid", awvalid, 1'b0);
        check_output("lit_reset_awaddr", awaddr, 32'h0);
        check_output("lit_reset_wr_err", wr_err, 1'b0);

        bvalid = 1'b1; bid = 4'h1; finish_wd = 1'b1;
        @(posedge clk); #1;
        bvalid = 1'b0; finish_wd = 1'b0;
        check_output("lit_idle_bready", bready, 1'b0);
        check_output("lit_idle_done", req0_done, 1'b0);

        raise(0, 32'h1000, 128'h0000000D_0000000C_0000000B_0000000A);
        raise(1, 32'h2000, 128'h0000001D_0000001C_0000001B_0000001A);
        serve(0, 32'h1000, 0, 0, 2'b00, 1'b0);
        serve(1, 32'h2000, 5, 0, 2'b00, 1'b0);

        raise(0, 32'h3000, 128'h3333);
        raise(1, 32'h4000, 128'h4444);
        serve(0, 32'h3000, 0, 1, 2'b00, 1'b0);
        serve(1, 32'h4000, 1, 0, 2'b00, 1'b0);

        raise(0, 32'h5000, 128'h5555);
        serve(0, 32'h5000, 0, 0, 2'b00, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_output("lit_post_rst_awvalid", awvalid, 1'b0);

        raise(0, 32'h6000, 128'h6666);
        raise(1, 32'h7000, 128'h7777);
        serve(0, 32'h6000, 0, 0, 2'b00, 1'b0);
        serve(1, 32'h7000, 0, 0, 2'b10, 1'b0);
`ifdef BRESP_CHK_EN
        check_output("lit_err_set", wr_err, 1'b1);
        check_output("lit_err_id", err_id, 4'h2);
`else
        check_output("lit_err_off", wr_err, 1'b0);
`endif
        raise(0, 32'h8000, 128'h8888);
        serve(0, 32'h8000, 0, 0, 2'b11, 1'b0);
`ifdef BRESP_CHK_EN
        check_output("lit_err_sticky", wr_err, 1'b1);
        check_output("lit_err_id_kept", err_id, 4'h2);
`else
        check_output("lit_err_id_off", err_id, 4'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameters SHALL be: ID_REQ0, 4'h1, AXI ID for requester 0; ID_REQ1, 4'h2, AXI ID for requester 1.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_rq  input  1  requester 0 write request, held until req0_ack.
REQ-005 req0_addr  input  32  requester 0 burst start address.
REQ-006 req0_wdata  input  128  requester 0 line data, beat0 = [31:0].
REQ-007 req0_ack  output  1  one-cycle accept pulse to requester 0.
REQ-008 req0_done  output  1  one-cycle write-complete pulse to requester 0.
REQ-009 req1_rq, req1_addr, req1_wdata, req1_ack, req1_done SHALL mirror REQ-004..008 for requester 1.
REQ-010 awvalid  output  1 / awready  input  1 / awaddr  output  32 / awid  output  4  AXI write-address channel.
REQ-011 awlen  output  8 / awsize  output  3 / awburst  output  2  SHALL be constants 8'd3, 3'd2, 2'b01.
REQ-012 next_rq  output  1 / next_id  output  4 / next_wdata  output  128  command to write-data channel manager.
REQ-013 finish_wd  input  1 / finish_id  input  4  last-beat accepted indication from write-data channel manager.
REQ-014 bvalid  input  1 / bready  output  1 / bid  input  4 / bresp  input  2  AXI write-response channel.
REQ-015 wr_err  output  1 / err_id  output  4  sticky error flag and ID of first failing write.

Function
REQ-016 FSM states SHALL be IDLE, AW, WST, WD, BR; unused encodings SHALL go to IDLE next cycle.
REQ-017 IDLE: if any rq, grant per REQ-018, pulse that reqN_ack, latch addr, wdata, ID_REQN into holding registers, go AW; else stay.
REQ-018 Arbitration SHALL be round-robin: single request wins; both requesting -> requester not granted last; after reset requester 0 has priority.
REQ-019 AW: awvalid=1 with awaddr/awid from holding registers, stable until awready; awready -> WST.
REQ-020 WST: next_rq=1 for exactly one cycle, then WD.
REQ-021 next_id and next_wdata SHALL be driven from holding registers from WST until return to IDLE, unchanged.
REQ-022 WD: finish_wd=1 -> BR; finish_wd outside WD SHALL be ignored.
REQ-023 BR: bready=1; bvalid & bid==held ID -> pulse reqN_done for granted requester, go IDLE.
REQ-024 BR with bvalid & bid!=held ID: response consumed (bready=1), discarded, stay BR.
REQ-025 bready SHALL be 0 outside BR; bvalid outside BR SHALL have no effect.
REQ-026 Only one transaction outstanding; new grant no earlier than cycle after done pulse; min IDLE->IDLE with zero-wait slaves 4 cycles plus burst.
REQ-027 Requester deasserting rq before ack SHALL be treated as withdrawn; no ack, no transaction.

Reset
REQ-028 rst=1 at any clock edge SHALL force IDLE, RR pointer to requester 0, clear holding registers.
REQ-029 Reset values: awvalid, next_rq, bready, req0/1_ack, req0/1_done, wr_err = 0; awaddr, awid, next_id, next_wdata, err_id = 0.
REQ-030 Reset mid-transaction SHALL abandon it without done pulse; no AW/W/B activity until new request post-reset.

Configuration
REQ-031 Macro BRESP_CHK_EN defined: accepted matching response with bresp!=2'b00 SHALL set wr_err and load err_id with bid if wr_err was 0; done still pulses; wr_err cleared only by rst.
REQ-032 BRESP_CHK_EN undefined: bresp ignored; wr_err and err_id tied 0.

Verification
REQ-033 Single: req0_rq, addr 32'h1000, zero-wait slave -> req0_ack pulse, awaddr 32'h1000 awid 4'h1 awlen 3, next_rq one cycle, bready, bid 4'h1 -> req0_done one cycle.
REQ-034 Contention: req0 and req1 same cycle after reset -> req0 first; both again -> req1 next; then req0.
REQ-035 Backpressure: awready low 5 cycles -> awvalid/awaddr stable 5 cycles, next_rq only after awready.
REQ-036 Wrong ID: in BR, bvalid bid 4'h7 then bid 4'h1 -> first discarded, done on second only.
REQ-037 Reset during WD: rst one cycle -> all outputs reset values next cycle, no done pulse, later request completes normally.
REQ-038 BRESP_CHK_EN: bresp 2'b10 bid 4'h2 -> wr_err=1, err_id=4'h2, req1_done pulses; later bresp 2'b11 bid 4'h1 leaves err_id=4'h2.
